// File: rtl/core_pkg.sv
// core_pkg: shared LSU state encoding, register-selector default and bus widths
package core_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} lsu_state_e;
  localparam int RF_SEL_W_DEF = 3;
  localparam int BUS_W = 8;
  localparam int WORD_W = 16;
endpackage

// File: rtl/lsu_rd_assemble.sv
// lsu_rd_assemble: builds the write-back word from captured bus bytes, extending byte loads
module lsu_rd_assemble
  import core_pkg::*;
(
  input  logic [BUS_W-1:0]  lo_i,
  input  logic [BUS_W-1:0]  hi_i,
  input  logic              byte_i,
  input  logic              sext_i,
  output logic [WORD_W-1:0] word_o
);
  always_comb begin
    word_o = byte_i ? {{BUS_W{sext_i & lo_i[BUS_W-1]}}, lo_i} : {hi_i, lo_i};
  end
endmodule

// File: rtl/lsu_16b.sv
// lsu_16b: 16-bit load/store unit over an 8-bit little-endian bus; LSU_BYTE_MODE_EN adds byte accesses
module lsu_16b
  import core_pkg::*;
#(
  parameter int RF_SEL_W = RF_SEL_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sched_lsu_req,
  input  logic                sched_lsu_we,
`ifdef LSU_BYTE_MODE_EN
  input  logic                sched_lsu_byte,
  input  logic                sched_lsu_sext,
`endif
  input  logic [RF_SEL_W-1:0] sched_lsu_dst,
  output logic                lsu_ready,
  input  logic [15:0]         lsu_adr,
  input  logic [15:0]         lsu_payload,
  output logic                mem_req,
  output logic                mem_we,
  output logic [15:0]         mem_adr,
  output logic [7:0]          mem_dout,
  input  logic [7:0]          mem_din,
  input  logic                mem_ack,
  output logic                rf_wr_en,
  output logic [RF_SEL_W-1:0] rf_wr_sel,
  output logic [15:0]         rf_wr_data
);
  lsu_state_e state_q, state_d;
  logic [15:0] adr_q, pay_q;
  logic [RF_SEL_W-1:0] dst_q;
  logic [7:0] lo_q, hi_q;
  logic we_q, byte_q, sext_q, busy;
  logic [15:0] asm_word;
`ifndef LSU_BYTE_MODE_EN
  assign byte_q = 1'b0;
  assign sext_q = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = sched_lsu_req ? LO : IDLE;
      LO:   state_d = mem_ack ? (byte_q ? DONE : HI) : LO;
      HI:   state_d = mem_ack ? DONE : HI;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q <= '0;
      pay_q <= '0;
      dst_q <= '0;
      we_q <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
`ifdef LSU_BYTE_MODE_EN
      byte_q <= 1'b0;
      sext_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && sched_lsu_req) begin
        adr_q <= lsu_adr;
        pay_q <= lsu_payload;
        dst_q <= sched_lsu_dst;
        we_q <= sched_lsu_we;
`ifdef LSU_BYTE_MODE_EN
        byte_q <= sched_lsu_byte;
        sext_q <= sched_lsu_sext;
`endif
      end
      if (state_q == LO && mem_ack && !we_q) lo_q <= mem_din;
      if (state_q == HI && mem_ack && !we_q) hi_q <= mem_din;
    end
  end
  lsu_rd_assemble u_asm (
    .lo_i   (lo_q),
    .hi_i   (hi_q),
    .byte_i (byte_q),
    .sext_i (sext_q),
    .word_o (asm_word)
  );
  // bus and write-back outputs decode only from state and latched values
  assign busy       = state_q == LO || state_q == HI;
  assign lsu_ready  = state_q == IDLE || !rst_n;
  assign mem_req    = busy;
  assign mem_we     = busy && we_q;
  assign mem_adr    = state_q == HI ? adr_q + 16'd1 : adr_q;
  assign mem_dout   = state_q == HI ? pay_q[15:8] : pay_q[7:0];
  assign rf_wr_en   = state_q == DONE && !we_q;
  assign rf_wr_sel  = dst_q;
  assign rf_wr_data = rf_wr_en ? asm_word : 16'h0000;
endmodule

// File: tb/tb_lsu_16b.sv
// tb_lsu_16b: directed self-checking bench for lsu_16b (byte cases under LSU_BYTE_MODE_EN)
module tb_lsu_16b;
  logic clk, rst_n, req, we, ack, ready, mreq, mwe, wen;
  logic [2:0] dst, wsel;
  logic [15:0] adr, pay, madr, wdata;
  logic [7:0] din, dout;
`ifdef LSU_BYTE_MODE_EN
  logic bt, sx;
`endif
  int tests = 0, fails = 0;

  lsu_16b #(.RF_SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sched_lsu_req(req), .sched_lsu_we(we),
`ifdef LSU_BYTE_MODE_EN
    .sched_lsu_byte(bt), .sched_lsu_sext(sx),
`endif
    .sched_lsu_dst(dst), .lsu_ready(ready), .lsu_adr(adr), .lsu_payload(pay),
    .mem_req(mreq), .mem_we(mwe), .mem_adr(madr), .mem_dout(dout),
    .mem_din(din), .mem_ack(ack), .rf_wr_en(wen), .rf_wr_sel(wsel), .rf_wr_data(wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 0; req = 0; we = 0; dst = 0; adr = 0; pay = 0; din = 0; ack = 0;
`ifdef LSU_BYTE_MODE_EN
    bt = 0; sx = 0;
`endif
    #1 chk("ready_in_reset", ready, 1);
    tick; tick;
    chk("rst_req", mreq, 0); chk("rst_we", mwe, 0); chk("rst_adr", madr, 0);
    chk("rst_dout", dout, 0); chk("rst_wen", wen, 0); chk("rst_wdata", wdata, 0);
    chk("rst_wsel", wsel, 0); chk("rst_ready", ready, 1);
    rst_n = 1;
    // word load 0x1234, zero wait
    req = 1; we = 0; adr = 16'h1234; dst = 3'd5; ack = 1;
    tick; req = 0; din = 8'h34;
    chk("wl_lo_req", mreq, 1); chk("wl_lo_adr", madr, 16'h1234); chk("wl_lo_we", mwe, 0);
    chk("wl_lo_ready", ready, 0); chk("wl_lo_wen", wen, 0);
    tick; din = 8'h12;
    chk("wl_hi_adr", madr, 16'h1235); chk("wl_hi_wen", wen, 0); chk("wl_hi_wdata", wdata, 0);
    tick;
    chk("wl_done_wen", wen, 1); chk("wl_done_data", wdata, 16'h1234);
    chk("wl_done_sel", wsel, 5); chk("wl_done_req", mreq, 0);
    tick;
    chk("wl_idle_wen", wen, 0); chk("wl_idle_ready", ready, 1);
    // word store 0xBEEF at 0xFFFF, wraps to 0x0000
    req = 1; we = 1; adr = 16'hFFFF; pay = 16'hBEEF;
    tick; req = 0;
    chk("ws_lo_we", mwe, 1); chk("ws_lo_adr", madr, 16'hFFFF); chk("ws_lo_dout", dout, 8'hEF);
    tick;
    chk("ws_hi_we", mwe, 1); chk("ws_hi_adr", madr, 16'h0000); chk("ws_hi_dout", dout, 8'hBE);
    tick;
    chk("ws_done_wen", wen, 0); chk("ws_done_req", mreq, 0);
    tick;
    chk("ws_idle_wen", wen, 0);
    // word load, two waits in LO, one in HI, request held throughout
    req = 1; we = 0; adr = 16'h4000; dst = 3'd2; ack = 0;
    tick;
    chk("wt_c1_adr", madr, 16'h4000); chk("wt_c1_req", mreq, 1);
    tick;
    chk("wt_c2_adr", madr, 16'h4000); chk("wt_c2_req", mreq, 1); chk("wt_c2_ready", ready, 0);
    tick; ack = 1; din = 8'hCD;
    chk("wt_c3_adr", madr, 16'h4000); chk("wt_c3_req", mreq, 1);
    tick; ack = 0;
    chk("wt_c4_adr", madr, 16'h4001); chk("wt_c4_ready", ready, 0);
    tick; ack = 1; din = 8'hAB;
    chk("wt_c5_adr", madr, 16'h4001); chk("wt_c5_req", mreq, 1); chk("wt_c5_wen", wen, 0);
    tick;
    chk("wt_c6_wen", wen, 1); chk("wt_c6_data", wdata, 16'hABCD);
    chk("wt_c6_sel", wsel, 2); chk("wt_c6_ready", ready, 0);
    tick;
    chk("wt_c7_ready", ready, 1); chk("wt_c7_wen", wen, 0);
    we = 1; adr = 16'h1111; pay = 16'h2233;
    tick; req = 0;
    chk("rs_lo_adr", madr, 16'h1111); chk("rs_lo_dout", dout, 8'h33); chk("rs_lo_we", mwe, 1);
    tick;
    chk("rs_hi_adr", madr, 16'h1112); chk("rs_hi_dout", dout, 8'h22);
    rst_n = 0;
    tick;
    chk("rs_req", mreq, 0); chk("rs_we", mwe, 0); chk("rs_adr", madr, 0);
    chk("rs_dout", dout, 0); chk("rs_wen", wen, 0); chk("rs_ready", ready, 1);
    rst_n = 1;
    #1 chk("rs_idle_ready", ready, 1);
    // load after reset proceeds normally
    req = 1; we = 0; adr = 16'h0010; dst = 3'd7; ack = 1;
    tick; req = 0; din = 8'h55;
    chk("pr_lo_adr", madr, 16'h0010); chk("pr_lo_req", mreq, 1);
    tick; din = 8'h66;
    chk("pr_hi_adr", madr, 16'h0011);
    tick;
    chk("pr_done_wen", wen, 1); chk("pr_done_data", wdata, 16'h6655); chk("pr_done_sel", wsel, 7);
    tick;
`ifdef LSU_BYTE_MODE_EN
    // byte loads of 0x80, sign- and zero-extended, single bus cycle
    req = 1; we = 0; bt = 1; sx = 1; adr = 16'h0020; dst = 3'd1; ack = 1;
    tick; req = 0; din = 8'h80;
    chk("bs_lo_adr", madr, 16'h0020);
    tick;
    chk("bs_done_wen", wen, 1); chk("bs_done_data", wdata, 16'hFF80); chk("bs_done_req", mreq, 0);
    tick;
    req = 1; sx = 0;
    tick; req = 0; din = 8'h80;
    tick;
    chk("bz_done_wen", wen, 1); chk("bz_done_data", wdata, 16'h0080);
    tick;
    // byte store touches only one bus cycle
    req = 1; we = 1; adr = 16'h0030; pay = 16'h9A5C;
    tick; req = 0;
    chk("bw_lo_dout", dout, 8'h5C); chk("bw_lo_we", mwe, 1);
    tick;
    chk("bw_done_req", mreq, 0); chk("bw_done_wen", wen, 0);
    tick;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
